instr_type_decode: RTL and testbench

//  Pipelined instruction-type decoder. Accepts raw 32-bit RV32I instructions with PC over valid/ready.

---
 rtl/riscv_pkg.sv | 94 +++++++++
 rtl/instr_type_decode_if.sv | 50 +++++
 rtl/decode_skid_buf.sv | 59 +++++
 rtl/instr_type_decode.sv | 67 ++++++
 tb/tb_instr_type_decode.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the instruction-type decoder.
// Contents:
//   XLEN, CNT_W       datapath width and illegal-counter width
//   OP_*              base opcodes of the nine recognised instruction types
//   type_idx_e        bit index of each type inside the one-hot type vector
//   imm_fmt_e         immediate encoding selector
//   decoded_t         registered bundle handed to control decode
//   decode_instr()    combinational classifier and field/immediate extractor
// Optional feature macro: ILLEGAL_DETECT_EN adds the 'illegal' flag to decoded_t.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  typedef enum logic [3:0] {
    T_R = 4'd0, T_I, T_L, T_S, T_B, T_J, T_JR, T_LUI, T_AUI
  } type_idx_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
  } imm_fmt_e;

  typedef struct packed {
    logic [8:0]      typ;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
`ifdef ILLEGAL_DETECT_EN
    logic            illegal;
`endif
  } decoded_t;

  function automatic decoded_t decode_instr(input logic [31:0] instr,
                                            input logic [XLEN-1:0] pc);
    decoded_t  d;
    type_idx_e ti;
    imm_fmt_e  fmt;
    logic      known;
    d     = '0;
    ti    = T_R;
    fmt   = IMM_NONE;
    known = 1'b1;
    case (instr[6:0])
      OP_R:    begin ti = T_R;   fmt = IMM_NONE; end
      OP_I:    begin ti = T_I;   fmt = IMM_I;    end
      OP_L:    begin ti = T_L;   fmt = IMM_I;    end
      OP_S:    begin ti = T_S;   fmt = IMM_S;    end
      OP_B:    begin ti = T_B;   fmt = IMM_B;    end
      OP_J:    begin ti = T_J;   fmt = IMM_J;    end
      OP_JR:   begin ti = T_JR;  fmt = IMM_I;    end
      OP_LUI:  begin ti = T_LUI; fmt = IMM_U;    end
      OP_AUI:  begin ti = T_AUI; fmt = IMM_U;    end
      default: known = 1'b0;
    endcase
    // Fields are extracted unconditionally; control decode ignores the ones a type does not use.
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct7 = instr[31:25];
    d.pc     = pc;
    if (known) d.typ = 9'(1) << ti;
    case (fmt)
      IMM_I:   d.imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   d.imm = {instr[31:12], 12'b0};
      default: d.imm = '0;
    endcase
`ifdef ILLEGAL_DETECT_EN
    // Every valid opcode ends in 2'b11, so a compressed-looking word is already unknown;
    // the explicit test keeps the intent visible.
    d.illegal = !known || (instr[1:0] != 2'b11);
    if (d.illegal) d.typ = '0;
`endif
    return d;
  endfunction

endpackage

// File: rtl/instr_type_decode_if.sv
// Fetch-side and control-side channels of the instruction-type decoder.
// Handshake: on each side a transfer happens at a rising clk edge where valid && ready are
// both high; a source holds valid and its payload steady until that edge, and a sink may
// raise or lower ready freely.
// Signals: in_valid/in_ready/in_instr/in_pc (fetch -> decoder),
//          out_valid/out_ready/out_type/out_rd/out_rs1/out_rs2/out_funct3/out_funct7/
//          out_imm/out_pc (decoder -> control decode),
//          out_illegal/illegal_cnt only when ILLEGAL_DETECT_EN is defined.
// Modports: slave = decoder, master = the surrounding fetch/control logic.
interface instr_type_decode_if;
  import riscv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_type;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
`ifdef ILLEGAL_DETECT_EN
  logic            out_illegal;
  logic [CNT_W-1:0] illegal_cnt;
`endif

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_pc
`ifdef ILLEGAL_DETECT_EN
    , output out_illegal, illegal_cnt
`endif
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_type, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_pc
`ifdef ILLEGAL_DETECT_EN
    , input out_illegal, illegal_cnt
`endif
  );

endinterface

// File: rtl/decode_skid_buf.sv
// Generic two-entry valid/ready skid buffer (main output register + one skid register).
// Ports: clk, reset (async, active-high), flush (sync, drops both entries),
//        i_valid/o_ready/i_data upstream, o_valid/i_ready/o_data downstream.
// o_ready comes straight from the skid-valid flop, so it is registered. The main entry only
// changes when it is empty or being handed off, which keeps o_data steady while stalled.
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;
  logic         w_in_hs;
  logic         w_out_hs;

  assign o_ready  = !r_skid_valid;
  assign o_valid  = r_main_valid;
  assign o_data   = r_main_data;
  assign w_in_hs  = i_valid && !r_skid_valid;
  assign w_out_hs = r_main_valid && i_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_out_hs) begin
      // Main slot frees up: the older skid entry goes first to keep FIFO order.
      // No new word can arrive while skid is full because o_ready is low then.
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_in_hs;
        if (w_in_hs) r_main_data <= i_data;
      end
    end else if (w_in_hs) begin
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_type_decode.sv
// Pipelined RV32I instruction-type decoder between fetch and control decode.
// Each accepted word is classified into a one-hot type {aui,lui,Jr,J,B,S,L,I,R} (bit0 = R),
// its register fields and sign-extended immediate are extracted, and the bundle is presented
// registered one cycle after acceptance through a two-entry skid buffer.
// Ports: clk, reset (async, active-high), flush (sync drop of all buffered words),
//        bus (instr_type_decode_if.slave: fetch-side and control-side channels).
// Optional feature macro: ILLEGAL_DETECT_EN adds out_illegal and a saturating illegal_cnt
// that counts delivered illegal words and is cleared only by reset.
module instr_type_decode
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  instr_type_decode_if.slave    bus
);

  localparam int BW = $bits(decoded_t);

  decoded_t      w_dec;
  decoded_t      w_out;
  logic [BW-1:0] w_out_bits;
  logic          w_out_valid;

  assign w_dec = decode_instr(bus.in_instr, bus.in_pc);

  decode_skid_buf #(.W(BW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .i_valid (bus.in_valid),
    .o_ready (bus.in_ready),
    .i_data  (w_dec),
    .o_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_out_bits)
  );

  assign w_out          = decoded_t'(w_out_bits);
  assign bus.out_valid  = w_out_valid;
  assign bus.out_type   = w_out.typ;
  assign bus.out_rd     = w_out.rd;
  assign bus.out_rs1    = w_out.rs1;
  assign bus.out_rs2    = w_out.rs2;
  assign bus.out_funct3 = w_out.funct3;
  assign bus.out_funct7 = w_out.funct7;
  assign bus.out_imm    = w_out.imm;
  assign bus.out_pc     = w_out.pc;

`ifdef ILLEGAL_DETECT_EN
  logic [CNT_W-1:0] r_illegal_cnt;

  assign bus.out_illegal = w_out.illegal;
  assign bus.illegal_cnt = r_illegal_cnt;

  // A handshake coinciding with flush is discarded, so it is not counted either.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_illegal_cnt <= '0;
    end else if (!flush && w_out_valid && bus.out_ready && w_out.illegal &&
                 (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_type_decode.sv
module tb_instr_type_decode;

  logic clk;
  logic reset;
  logic flush;
  int   n_checks;
  int   n_fail;
  int   n_deliv;
  logic [31:0] exp_q[$];

  instr_type_decode_if bus ();

  instr_type_decode dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- driver / scoreboard ----------------
  // One clock cycle. Handshakes are sampled just before the edge; accepted PCs are queued,
  // delivered PCs are popped and compared in order.
  task automatic tick(output logic acc);
    logic        hs_in, hs_out, was_flush;
    logic [31:0] in_pc_s, out_pc_s;
    hs_in     = bus.in_valid && bus.in_ready;
    hs_out    = bus.out_valid && bus.out_ready;
    was_flush = flush;
    in_pc_s   = bus.in_pc;
    out_pc_s  = bus.out_pc;
    if (bus.out_valid && !bus.out_ready && !flush && exp_q.size() > 0)
      check_eq("stall_hold_pc", out_pc_s, exp_q[0]);
    @(posedge clk);
    #1;
    acc = hs_in && !was_flush;
    if (was_flush) begin
      exp_q.delete();
    end else begin
      if (hs_out) begin
        check_eq("deliver_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_eq("order_pc", out_pc_s, exp_q.pop_front());
          n_deliv++;
        end
      end
      if (hs_in) exp_q.push_back(in_pc_s);
    end
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    tick(acc);
    check_eq("send_accept", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   k;
    int   cycles;
    n_checks = 0;
    n_fail   = 0;
    n_deliv  = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_type", 32'(bus.out_type), 32'd0);
    check_eq("rst_out_imm", bus.out_imm, 32'd0);
    check_eq("rst_out_pc", bus.out_pc, 32'd0);
    check_eq("rst_out_rd", 32'(bus.out_rd), 32'd0);
`ifdef ILLEGAL_DETECT_EN
    check_eq("rst_illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed decode vectors, downstream always ready.
    bus.out_ready = 1'b1;
    send(32'h00500093, 32'h00000100);                 // addi x1,x0,5
    check_eq("addi_valid", 32'(bus.out_valid), 32'd1);
    check_eq("addi_type", 32'(bus.out_type), 32'h002);
    check_eq("addi_rd", 32'(bus.out_rd), 32'd1);
    check_eq("addi_rs1", 32'(bus.out_rs1), 32'd0);
    check_eq("addi_imm", bus.out_imm, 32'd5);
    check_eq("addi_pc", bus.out_pc, 32'h100);

    send(32'h0020A423, 32'h00000104);                 // sw x2,8(x1)
    check_eq("sw_type", 32'(bus.out_type), 32'h008);
    check_eq("sw_rs1", 32'(bus.out_rs1), 32'd1);
    check_eq("sw_rs2", 32'(bus.out_rs2), 32'd2);
    check_eq("sw_funct3", 32'(bus.out_funct3), 32'd2);
    check_eq("sw_imm", bus.out_imm, 32'd8);

    send(32'h123452B7, 32'h00000108);                 // lui x5,0x12345
    check_eq("lui_type", 32'(bus.out_type), 32'h080);
    check_eq("lui_rd", 32'(bus.out_rd), 32'd5);
    check_eq("lui_imm", bus.out_imm, 32'h12345000);

    send(32'hFFDFF0EF, 32'h0000010C);                 // jal x1,-4
    check_eq("jal_type", 32'(bus.out_type), 32'h020);
    check_eq("jal_rd", 32'(bus.out_rd), 32'd1);
    check_eq("jal_imm", bus.out_imm, 32'hFFFFFFFC);

    send(32'hFE208EE3, 32'h00000110);                 // beq x1,x2,-4
    check_eq("beq_type", 32'(bus.out_type), 32'h010);
    check_eq("beq_imm", bus.out_imm, 32'hFFFFFFFC);

    send(32'h002081B3, 32'h00000114);                 // add x3,x1,x2
    check_eq("add_type", 32'(bus.out_type), 32'h001);
    check_eq("add_rd", 32'(bus.out_rd), 32'd3);
    check_eq("add_imm", bus.out_imm, 32'd0);

    send(32'hFFF00093, 32'h00000118);                 // addi x1,x0,-1
    check_eq("neg_imm", bus.out_imm, 32'hFFFFFFFF);

    send(32'h0000007F, 32'h0000011C);                 // unknown opcode
    check_eq("unk_type", 32'(bus.out_type), 32'd0);
    check_eq("unk_imm", bus.out_imm, 32'd0);
`ifdef ILLEGAL_DETECT_EN
    check_eq("unk_illegal", 32'(bus.out_illegal), 32'd1);
    check_eq("cnt_before_hs", 32'(bus.illegal_cnt), 32'd0);
    tick(acc);
    check_eq("cnt_after_hs", 32'(bus.illegal_cnt), 32'd1);
`else
    tick(acc);
`endif
    check_eq("drain_directed", 32'(exp_q.size()), 32'd0);

    // Stream of four with downstream stalled for three cycles.
    bus.out_ready = 1'b0;
    n_deliv = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00100093;
    bus.in_pc = 32'h2000;
    tick(acc);
    check_eq("s_acc0", 32'(acc), 32'd1);
    bus.in_pc = 32'h2004;
    tick(acc);
    check_eq("s_acc1", 32'(acc), 32'd1);
    check_eq("in_ready_drop", 32'(bus.in_ready), 32'd0);
    bus.in_pc = 32'h2008;
    tick(acc);
    check_eq("s_full_no_accept", 32'(acc), 32'd0);
    check_eq("s_stall_pc", bus.out_pc, 32'h2000);
    bus.out_ready = 1'b1;
    k = 2;
    cycles = 0;
    for (int c = 0; c < 10 && n_deliv < 4; c++) begin
      check_eq("no_bubble", 32'(bus.out_valid), 32'd1);
      tick(acc);
      cycles++;
      if (acc) begin
        k++;
        if (k < 4) bus.in_pc = 32'h2000 + 32'(4 * k);
        else bus.in_valid = 1'b0;
      end
    end
    check_eq("stream_delivered", 32'(n_deliv), 32'd4);
    check_eq("stream_cycles", 32'(cycles), 32'd4);
    bus.in_valid = 1'b0;

    // Flush with both entries full and a word offered.
    bus.out_ready = 1'b0;
    send(32'h00100093, 32'h3000);
    send(32'h00100093, 32'h3004);
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h3008;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick(acc);
    check_eq("flush_no_ghost", 32'(bus.out_valid), 32'd0);

    // Flush while a word is actually handshaken in the same cycle.
    bus.out_ready = 1'b0;
    send(32'h00100093, 32'h3010);
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h3014;
    flush = 1'b1;
    tick(acc);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_hs_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    tick(acc);
    check_eq("flush_hs_discard", 32'(bus.out_valid), 32'd0);
    send(32'h00100093, 32'h3018);
    check_eq("post_flush_pc", bus.out_pc, 32'h3018);
    tick(acc);

    // Asynchronous reset in the middle of a stalled stream.
    bus.out_ready = 1'b0;
    send(32'h00100093, 32'h4000);
    send(32'h00100093, 32'h4004);
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("areset_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("areset_out_pc", bus.out_pc, 32'd0);
`ifdef ILLEGAL_DETECT_EN
    check_eq("areset_cnt", 32'(bus.illegal_cnt), 32'd0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h00100093, 32'h4010);
    check_eq("post_reset_pc", bus.out_pc, 32'h4010);

    // Final drain.
    for (int c = 0; c < 5 && exp_q.size() > 0; c++) tick(acc);
    check_eq("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
